// File: rtl/data_memory_responder_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LINE_W        = 256;
    localparam int unsigned LINE_OFFSET_W = 5;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the D-cache miss path and the memory responder.
// Optional feature macro: DMEM_RANGE_CHECK_EN adds err_o.
interface data_memory_responder_if;
    import dmem_pkg::*;

    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              busy_o;
`ifdef DMEM_RANGE_CHECK_EN
    logic              err_o;

    modport master (output enable_i, write_i, addr_i, data_i,
                    input  ack_o, data_o, busy_o, err_o);
    modport slave  (input  enable_i, write_i, addr_i, data_i,
                    output ack_o, data_o, busy_o, err_o);
`else
    modport master (output enable_i, write_i, addr_i, data_i,
                    input  ack_o, data_o, busy_o);
    modport slave  (input  enable_i, write_i, addr_i, data_i,
                    output ack_o, data_o, busy_o);
`endif

endinterface

// File: rtl/data_memory_responder_line_array.sv
// DEPTH x 256-bit line storage, synchronous write and registered read port.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic                     clr_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [LINE_W-1:0]        wdata_i,
    output logic [LINE_W-1:0]        rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];

    // Line write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register holds until the next read or clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (clr_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[idx_i];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency line responder for D-cache refills and writebacks.
// Optional feature macro: DMEM_RANGE_CHECK_EN (flags and suppresses
// accesses whose address lies beyond the array).
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_memory_responder_if.slave bus
);

    localparam int unsigned      IDX_W      = $clog2(DEPTH);
    localparam int unsigned      IDX_LO     = LINE_OFFSET_W;
    localparam int unsigned      IDX_HI     = LINE_OFFSET_W + IDX_W - 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic             DIRECT_ACK = (LATENCY == 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load, fire;
    logic               write_q, oor_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LINE_W-1:0]  wdata_q;
    logic               req_write, req_oor, live_oor;
    logic [IDX_W-1:0]   req_idx;
    logic [LINE_W-1:0]  req_wdata;
    logic               ack_q, busy_q;
    logic               mem_we, mem_re, mem_clr;
    logic [LINE_W-1:0]  rdata;
    logic               unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
    logic               err_q;
    assign live_oor    = (bus.addr_i[ADDR_W-1:IDX_HI+1] != '0);
    assign unused_addr = ^bus.addr_i[IDX_LO-1:0];
`else
    assign live_oor    = 1'b0;
    assign unused_addr = ^{bus.addr_i[ADDR_W-1:IDX_HI+1], bus.addr_i[IDX_LO-1:0]};
`endif

    // Live inputs feed the completion when LATENCY=1 enters ACK straight from IDLE.
    always_comb begin
        req_write = write_q;
        req_idx   = idx_q;
        req_wdata = wdata_q;
        req_oor   = oor_q;
        if (state_q == IDLE) begin
            req_write = bus.write_i;
            req_idx   = bus.addr_i[IDX_HI:IDX_LO];
            req_wdata = bus.data_i;
            req_oor   = live_oor;
        end
    end

    // Next-state, counter and completion strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    load  = 1'b1;
                    cnt_d = CNT_LOAD;
                    if (DIRECT_ACK) begin
                        state_d = ACK;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ACK;
                    fire    = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == ACK);
            busy_q  <= (state_d != IDLE);
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= fire & req_oor;
`endif
        end
    end

    // Capture the request on acceptance; only these copies are used afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
        end else if (load) begin
            write_q <= bus.write_i;
            idx_q   <= bus.addr_i[IDX_HI:IDX_LO];
            wdata_q <= bus.data_i;
            oor_q   <= live_oor;
        end
    end

    assign mem_we  = fire &  req_write & ~req_oor;
    assign mem_re  = fire & ~req_write & ~req_oor;
    assign mem_clr = fire & ~req_write &  req_oor;

    dmem_line_array #(.DEPTH(DEPTH)) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .clr_i   (mem_clr),
        .idx_i   (req_idx),
        .wdata_i (req_wdata),
        .rdata_o (rdata)
    );

    assign bus.ack_o  = ack_q;
    assign bus.busy_o = busy_q;
    assign bus.data_o = rdata;
`ifdef DMEM_RANGE_CHECK_EN
    assign bus.err_o  = err_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (LATENCY=10 and LATENCY=1 instances).
module tb_data_memory_responder;

    localparam int unsigned LAT = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_responder_if bus0();
    data_memory_responder_if bus1();

    data_memory_responder #(.LATENCY(LAT), .DEPTH(512)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    data_memory_responder #(.LATENCY(1), .DEPTH(512)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    typedef struct {
        logic         rd;
        logic         err;
        logic [255:0] data;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [255:0] mdl0[int];
    logic [255:0] mdl1[int];
    logic [255:0] last0, last1;
    int           checks = 0;
    int           errors = 0;

    function automatic logic oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a[31:14] != 18'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic ack_of(input bit sel);
        return sel ? bus1.ack_o : bus0.ack_o;
    endfunction

    // Drive one request for a single cycle and push its expected outcome.
    task automatic issue(input bit sel, input logic w, input logic [31:0] a, input logic [255:0] d);
        exp_t e;
        int   idx;
        idx   = int'(a[13:5]);
        e.rd  = !w;
        e.err = oor(a);
        if (sel == 1'b0) begin
            if (w) begin
                if (!e.err) mdl0[idx] = d;
                e.data = last0;
            end else begin
                e.data = e.err ? 256'h0 : mdl0[idx];
                last0  = e.data;
            end
            q0.push_back(e);
            bus0.enable_i = 1'b1; bus0.write_i = w; bus0.addr_i = a; bus0.data_i = d;
        end else begin
            if (w) begin
                if (!e.err) mdl1[idx] = d;
                e.data = last1;
            end else begin
                e.data = e.err ? 256'h0 : mdl1[idx];
                last1  = e.data;
            end
            q1.push_back(e);
            bus1.enable_i = 1'b1; bus1.write_i = w; bus1.addr_i = a; bus1.data_i = d;
        end
        @(negedge clk);
        bus0.enable_i = 1'b0;
        bus1.enable_i = 1'b0;
    endtask

    // Called one cycle after the accept cycle; lat counts cycles from accept, -1 on timeout.
    task automatic wait_ack(input bit sel, output int lat);
        lat = 1;
        while (!ack_of(sel) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!ack_of(sel)) lat = -1;
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus0.enable_i = 1'b0; bus0.write_i = 1'b0; bus0.addr_i = '0; bus0.data_i = '0;
        bus1.enable_i = 1'b0; bus1.write_i = 1'b0; bus1.addr_i = '0; bus1.data_i = '0;
        last0 = '0; last1 = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus0.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", bus0.ack_o); end
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", bus0.busy_o); end
        checks++; if (bus0.data_o !== 256'h0) begin errors++; $display("FAIL reset_data0: got %h want 0", bus0.data_o); end
        checks++; if (bus1.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b want 0", bus1.ack_o); end
        checks++; if (bus1.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", bus1.busy_o); end
        checks++; if (bus1.data_o !== 256'h0) begin errors++; $display("FAIL reset_data1: got %h want 0", bus1.data_o); end
`ifdef DMEM_RANGE_CHECK_EN
        checks++; if (bus0.err_o !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b want 0", bus0.err_o); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_latency();
        int           lat;
        exp_t         e;
        logic [255:0] pat;
        pat = {8{32'hDEADBEEF}};
        issue(0, 1'b1, 32'h40, pat);
        checks++; if (bus0.busy_o !== 1'b1) begin errors++; $display("FAIL busy_in_wait: got %b want 1", bus0.busy_o); end
        wait_ack(0, lat);
        e = q0.pop_front();
        checks++; if (lat !== LAT) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, LAT); end
        checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL write_keeps_data_o: got %h want %h", bus0.data_o, e.data); end
        @(negedge clk);
        checks++; if (bus0.ack_o !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b want 0", bus0.ack_o); end
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL busy_after_ack: got %b want 0", bus0.busy_o); end
        issue(0, 1'b0, 32'h40, rnd_line());
        wait_ack(0, lat);
        e = q0.pop_front();
        checks++; if (lat !== LAT) begin errors++; $display("FAIL read_latency: got %0d want %0d", lat, LAT); end
        checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL read_data: got %h want %h", bus0.data_o, e.data); end
        @(negedge clk);
    endtask

    task automatic test_offset_ignore();
        int          lat;
        exp_t        e;
        logic [31:0] addrs[7];
        logic        wr[7];
        addrs = '{32'h100, 32'h11F, 32'h2A4, 32'h3E0, 32'h2BF, 32'h3E7, 32'h2A0};
        wr    = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0};
        for (int i = 0; i < 7; i++) begin
            issue(0, wr[i], addrs[i], rnd_line());
            wait_ack(0, lat);
            e = q0.pop_front();
            checks++; if (lat !== LAT) begin errors++; $display("FAIL offset_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL offset_data[%0d]: got %h want %h", i, bus0.data_o, e.data); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int           lat;
        exp_t         e;
        logic         seen;
        logic [255:0] old;
        old = rnd_line();
        issue(0, 1'b1, 32'h80, old);
        wait_ack(0, lat);
        e = q0.pop_front();
        @(negedge clk);
        // Interrupted write: deliberately absent from the model.
        bus0.enable_i = 1'b1; bus0.write_i = 1'b1; bus0.addr_i = 32'h80; bus0.data_i = ~old;
        @(negedge clk);
        bus0.enable_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", bus0.busy_o); end
        @(negedge clk);
        rst = 1'b0;
        last0 = '0; last1 = '0;
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (bus0.ack_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_ack: got %b want 0", seen); end
        issue(0, 1'b0, 32'h80, '0);
        wait_ack(0, lat);
        e = q0.pop_front();
        checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL reset_mid_line_kept: got %h want %h", bus0.data_o, e.data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   lat, gap;
        exp_t e;
        e.rd = 1'b1; e.err = 1'b0; e.data = mdl0[2]; last0 = e.data; q0.push_back(e);
        bus0.enable_i = 1'b1; bus0.write_i = 1'b0; bus0.addr_i = 32'h40;
        @(negedge clk);
        wait_ack(0, lat);
        e = q0.pop_front();
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
        checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL b2b_first_data: got %h want %h", bus0.data_o, e.data); end
        // Second request is the one sampled in the IDLE cycle after ACK.
        bus0.addr_i = 32'h100;
        e.data = mdl0[8]; last0 = e.data; q0.push_back(e);
        gap = 1;
        @(negedge clk);
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b want 0", bus0.busy_o); end
        @(negedge clk);
        gap = 2;
        bus0.enable_i = 1'b0;
        while (!bus0.ack_o && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        e = q0.pop_front();
        checks++; if (gap !== LAT + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", gap, LAT + 1); end
        checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL b2b_second_data: got %h want %h", bus0.data_o, e.data); end
        @(negedge clk);
    endtask

    task automatic test_latency_one();
        int          lat;
        exp_t        e;
        logic [31:0] addrs[4];
        logic        wr[4];
        addrs = '{32'h40, 32'h40, 32'h60, 32'h7C};
        wr    = '{1'b1,   1'b0,   1'b1,   1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(1, wr[i], addrs[i], rnd_line());
            wait_ack(1, lat);
            e = q1.pop_front();
            checks++; if (lat !== 1) begin errors++; $display("FAIL lat1_latency[%0d]: got %0d want 1", i, lat); end
            checks++; if (bus1.data_o !== e.data) begin errors++; $display("FAIL lat1_data[%0d]: got %h want %h", i, bus1.data_o, e.data); end
            @(negedge clk);
            checks++; if (bus1.ack_o !== 1'b0) begin errors++; $display("FAIL lat1_ack_pulse[%0d]: got %b want 0", i, bus1.ack_o); end
        end
    endtask

`ifdef DMEM_RANGE_CHECK_EN
    task automatic test_range_check();
        int           lat;
        exp_t         e;
        logic [31:0]  addrs[4];
        logic         wr[4];
        addrs = '{32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000};
        wr    = '{1'b1,  1'b1,          1'b0,  1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(0, wr[i], addrs[i], rnd_line());
            wait_ack(0, lat);
            e = q0.pop_front();
            checks++; if (lat !== LAT) begin errors++; $display("FAIL range_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            checks++; if (bus0.err_o !== e.err) begin errors++; $display("FAIL range_err[%0d]: got %b want %b", i, bus0.err_o, e.err); end
            checks++; if (bus0.data_o !== e.data) begin errors++; $display("FAIL range_data[%0d]: got %h want %h", i, bus0.data_o, e.data); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_latency();
        test_offset_ignore();
        test_reset_mid_op();
        test_back_to_back();
        test_latency_one();
`ifdef DMEM_RANGE_CHECK_EN
        test_range_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
